valid_strobe_gen: RTL and testbench
===================================

Name: valid_strobe_gen

Overview:
Programmable periodic enable generator. Produces the single-cycle `o_valid` strobe consumed by the LED flash/shift blocks, so LEDs toggle at a switch-selected rate.
Run/idle and rate are controlled from board switches. Rate changes are applied only at a period boundary, so no short or long glitch periods occur.
Also reports the running strobe count for debug.

Parameters:
- NB_COUNTER, 32, width of the period counter.
- NB_SW, 4, width of the switch input (bit 0 = enable, bits 2:1 = rate select, bit 3 reserved/ignored).
- NB_PULSE, 8, width of the emitted-strobe counter.
- LIMIT_R0, (2**23)-1, terminal count for rate 0 (fastest).
- LIMIT_R1, (2**24)-1, terminal count for rate 1.
- LIMIT_R2, (2**25)-1, terminal count for rate 2.
- LIMIT_R3, (2**26)-1, terminal count for rate 3 (slowest).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
- i_sw  input  NB_SW  switches: [0] run enable, [2:1] rate select, [3] ignored.
- o_valid  output  1  registered strobe, high exactly one cycle per period.
- o_busy  output  1  1 while in RUN state.
- o_pulse_cnt  output  NB_PULSE  number of strobes emitted since reset; wraps modulo 2**NB_PULSE.

Behaviour:
- Reset (i_reset==0 at posedge):
  - state=IDLE; counter=0; rate_reg=0.
  - o_valid=0, o_busy=0, o_pulse_cnt=0.
  - Reset has priority over every other event, including a terminal-count cycle: no strobe is emitted.
- Limit mux: L = LIMIT_R{rate_reg}. All limits must fit in NB_COUNTER bits. L=0 is legal and gives o_valid high every cycle.
- FSM, two states, registered state, all outputs registered:
  - IDLE:
    - counter held at 0; o_valid=0.
    - If i_sw[0]==1: next state RUN, counter<=0, rate_reg<=i_sw[2:1].
  - RUN, i_sw[0]==0:
    - Next state IDLE; counter<=0; o_valid<=0.
    - Disable has priority over terminal count, so no strobe is emitted.
  - RUN, i_sw[0]==1 and counter!=L:
    - counter<=counter+1; o_valid<=0.
  - RUN, i_sw[0]==1 and counter==L:
    - counter<=0; o_valid<=1; o_pulse_cnt<=o_pulse_cnt+1 (wraps).
    - rate_reg<=i_sw[2:1]. This is the only point where a rate change takes effect in RUN.
- Timing:
  - Enable sampled high at edge E0 → RUN after E0 with counter=0.
  - First o_valid high in the cycle after edge E0+L+1.
  - Thereafter period = L+1 cycles, duty 1 cycle.
- o_busy = (state==RUN), registered with state.
- i_sw[3] has no effect.
- i_sw is assumed already synchronized/debounced upstream.

Test Plan:
All tests use overrides LIMIT_R0=3, LIMIT_R1=7, LIMIT_R2=15, LIMIT_R3=31, NB_PULSE=4.
1. Reset dominance: i_reset=0 for 3 cycles with i_sw=4'b0111 → o_valid=0, o_busy=0, o_pulse_cnt=0 throughout. Release → o_busy=1 after first edge; first strobe 32 cycles later.
2. Rate 0: i_sw=4'b0001 from IDLE → o_valid high one cycle after edges E0+4, E0+8, E0+12; o_pulse_cnt=1,2,3.
3. Boundary rate change: running rate 1, switch i_sw[2:1] to 3 when counter=2 → current period still ends 8 cycles after its start; subsequent periods are 32 cycles.
4. Disable mid-period and at terminal: clear i_sw[0] at counter=5 (rate 1) → IDLE next edge, counter=0, no strobe. Repeat with clear at counter==L → no strobe, o_pulse_cnt unchanged. Re-enable → full 8-cycle first period.
5. Strobe counter wrap: run rate 0 for 17 strobes → o_pulse_cnt reads 1 (17 mod 16).
6. Reset mid-run at terminal count: i_reset=0 in the cycle counter==L → o_valid stays 0; all outputs zero next cycle. After release with i_sw[0]=1 → restart from counter=0.

Source files
------------

// File: rtl/valid_strobe_gen.sv
// -----------------------------------------------------------------------------
// valid_strobe_gen
//
// Programmable periodic enable generator. While running, emits a one-cycle
// o_valid strobe every (L+1) clock cycles, where L is the terminal count for
// the rate selected on the switches. A new rate is latched only at a period
// boundary, so the strobe never produces a shortened or stretched period.
// A wrapping count of emitted strobes is exported for debug.
//
// Ports:
//   clock        in   system clock, rising-edge
//   i_reset      in   synchronous active-low reset
//   i_sw         in   [0] run enable, [2:1] rate select, [3] ignored
//   o_valid      out  registered strobe, one cycle per period
//   o_busy       out  high while in RUN
//   o_pulse_cnt  out  strobes emitted since reset, wraps modulo 2**NB_PULSE
// -----------------------------------------------------------------------------
module valid_strobe_gen #(
  parameter int          NB_COUNTER = 32,
  parameter int          NB_SW      = 4,
  parameter int          NB_PULSE   = 8,
  parameter int unsigned LIMIT_R0   = (2**23) - 1,
  parameter int unsigned LIMIT_R1   = (2**24) - 1,
  parameter int unsigned LIMIT_R2   = (2**25) - 1,
  parameter int unsigned LIMIT_R3   = (2**26) - 1
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic [NB_SW-1:0]    i_sw,
  output logic                o_valid,
  output logic                o_busy,
  output logic [NB_PULSE-1:0] o_pulse_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [NB_COUNTER-1:0] r_counter;
  logic [NB_COUNTER-1:0] w_counter_next;
  logic [NB_COUNTER-1:0] w_limit;
  logic [1:0]            r_rate;
  logic [1:0]            w_rate_next;
  logic                  r_valid;
  logic                  w_valid_next;
  logic [NB_PULSE-1:0]   r_pulse_cnt;
  logic [NB_PULSE-1:0]   w_pulse_next;

  logic       w_enable;
  logic [1:0] w_rate_sel;
  logic       w_unused_sw;

  assign w_enable    = i_sw[0];
  assign w_rate_sel  = i_sw[2:1];
  // Reserved switch bits are intentionally ignored.
  assign w_unused_sw = ^i_sw[NB_SW-1:3];

  // Terminal count for the rate latched at the last period boundary.
  always_comb begin
    case (r_rate)
      2'd0:    w_limit = NB_COUNTER'(LIMIT_R0);
      2'd1:    w_limit = NB_COUNTER'(LIMIT_R1);
      2'd2:    w_limit = NB_COUNTER'(LIMIT_R2);
      default: w_limit = NB_COUNTER'(LIMIT_R3);
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    w_state_next   = r_state;
    w_counter_next = r_counter;
    w_rate_next    = r_rate;
    w_valid_next   = 1'b0;
    w_pulse_next   = r_pulse_cnt;

    case (r_state)
      ST_IDLE: begin
        w_counter_next = '0;
        if (w_enable) begin
          w_state_next = ST_RUN;
          w_rate_next  = w_rate_sel;
        end
      end
      ST_RUN: begin
        if (!w_enable) begin
          // Disable wins over a coincident terminal count: no strobe.
          w_state_next   = ST_IDLE;
          w_counter_next = '0;
        end else if (r_counter == w_limit) begin
          w_counter_next = '0;
          w_valid_next   = 1'b1;
          w_pulse_next   = r_pulse_cnt + NB_PULSE'(1);
          // Period boundary: the only place a rate change is accepted.
          w_rate_next    = w_rate_sel;
        end else begin
          w_counter_next = r_counter + NB_COUNTER'(1);
        end
      end
      default: begin
        w_state_next   = ST_IDLE;
        w_counter_next = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!i_reset) begin
      // Reset overrides everything, including a terminal-count cycle.
      r_state     <= ST_IDLE;
      r_counter   <= '0;
      r_rate      <= 2'd0;
      r_valid     <= 1'b0;
      r_pulse_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_counter   <= w_counter_next;
      r_rate      <= w_rate_next;
      r_valid     <= w_valid_next;
      r_pulse_cnt <= w_pulse_next;
    end
  end

  assign o_valid     = r_valid;
  assign o_busy      = (r_state == ST_RUN);
  assign o_pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_valid_strobe_gen.sv
// -----------------------------------------------------------------------------
// tb_valid_strobe_gen
//
// Directed bench for valid_strobe_gen with small terminal counts
// (3/7/15/31) and a 4-bit strobe counter. Expected strobes (cycle index and
// counter value) are queued when the stimulus is applied and consumed as the
// DUT raises o_valid; any strobe that is early, late, missing or unexpected
// is reported.
// -----------------------------------------------------------------------------
module tb_valid_strobe_gen;

  localparam int NB_PULSE = 4;

  logic                clock;
  logic                i_reset;
  logic [3:0]          i_sw;
  logic                o_valid;
  logic                o_busy;
  logic [NB_PULSE-1:0] o_pulse_cnt;

  valid_strobe_gen #(
    .NB_COUNTER (32),
    .NB_SW      (4),
    .NB_PULSE   (NB_PULSE),
    .LIMIT_R0   (3),
    .LIMIT_R1   (7),
    .LIMIT_R2   (15),
    .LIMIT_R3   (31)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_sw        (i_sw),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
    .o_pulse_cnt (o_pulse_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   exp_cnt = 0;
  int   e0      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic expect_strobe(input int at);
    exp_cnt = (exp_cnt + 1) % (2**NB_PULSE);
    sb.push_back('{cyc: at, cnt: exp_cnt});
  endtask

  // Advance one edge, sample 1 ns later, and reconcile strobes with the queue.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("missed_strobe", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {31'd0, o_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("strobe_cyc", cyc, e.cyc);
        check("strobe_cnt", {28'd0, o_pulse_cnt}, e.cnt);
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    i_sw    = 4'b0000;
    tick();
    check("rst_valid", {31'd0, o_valid}, 0);
    check("rst_busy",  {31'd0, o_busy},  0);
    check("rst_cnt",   {28'd0, o_pulse_cnt}, 0);
    exp_cnt = 0;
    i_reset = 1'b1;
  endtask

  initial begin
    i_reset = 1'b0;
    i_sw    = 4'b0000;

    // 1. Reset dominance with enable and rate 3 held on the switches.
    i_sw = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_rst_valid", {31'd0, o_valid}, 0);
      check("t1_rst_busy",  {31'd0, o_busy},  0);
      check("t1_rst_cnt",   {28'd0, o_pulse_cnt}, 0);
    end
    i_reset = 1'b1;
    tick();
    e0 = cyc;
    check("t1_busy_after_release", {31'd0, o_busy}, 1);
    expect_strobe(e0 + 32);
    drain(40);
    i_sw = 4'b0000;
    tick();
    check("t1_idle_busy", {31'd0, o_busy}, 0);

    // 2. Rate 0 from IDLE: strobes every 4 cycles, count 1,2,3.
    do_reset();
    i_sw = 4'b0001;
    tick();
    e0 = cyc;
    for (int k = 1; k <= 3; k++) expect_strobe(e0 + 4 * k);
    drain(20);
    check("t2_cnt", {28'd0, o_pulse_cnt}, 3);
    i_sw = 4'b0000;
    tick();
    check("t2_idle_busy", {31'd0, o_busy}, 0);

    // 3. Rate change mid-period only takes effect at the boundary.
    i_sw = 4'b0011;
    tick();
    e0 = cyc;
    tick();
    tick();
    i_sw = 4'b0111;
    expect_strobe(e0 + 8);
    expect_strobe(e0 + 40);
    expect_strobe(e0 + 72);
    drain(80);
    i_sw = 4'b0110;
    tick();
    check("t3_idle_busy", {31'd0, o_busy}, 0);

    // 4a. Disable mid-period (counter=5, rate 1).
    i_sw = 4'b0011;
    tick();
    for (int i = 0; i < 5; i++) tick();
    i_sw = 4'b0010;
    tick();
    check("t4a_busy", {31'd0, o_busy}, 0);
    check("t4a_cnt",  {28'd0, o_pulse_cnt}, exp_cnt);
    tick();
    tick();

    // 4b. Disable exactly at terminal count: no strobe, count unchanged.
    i_sw = 4'b0011;
    tick();
    for (int i = 0; i < 7; i++) tick();
    i_sw = 4'b0010;
    tick();
    check("t4b_valid", {31'd0, o_valid}, 0);
    check("t4b_busy",  {31'd0, o_busy},  0);
    check("t4b_cnt",   {28'd0, o_pulse_cnt}, exp_cnt);

    // 4c. Re-enable: full 8-cycle first period.
    i_sw = 4'b0011;
    tick();
    e0 = cyc;
    check("t4c_busy", {31'd0, o_busy}, 1);
    expect_strobe(e0 + 8);
    drain(12);
    i_sw = 4'b0000;
    tick();

    // 5. Strobe counter wraps: 17 strobes on a 4-bit counter reads 1.
    do_reset();
    i_sw = 4'b1001;
    tick();
    e0 = cyc;
    for (int k = 1; k <= 17; k++) expect_strobe(e0 + 4 * k);
    drain(80);
    check("t5_wrap_cnt", {28'd0, o_pulse_cnt}, 1);
    i_sw = 4'b0000;
    tick();

    // 6. Reset asserted in the terminal-count cycle suppresses the strobe.
    i_sw = 4'b0001;
    tick();
    e0 = cyc;
    expect_strobe(e0 + 4);
    drain(8);
    tick();
    tick();
    tick();
    i_reset = 1'b0;
    tick();
    check("t6_valid", {31'd0, o_valid}, 0);
    check("t6_busy",  {31'd0, o_busy},  0);
    check("t6_cnt",   {28'd0, o_pulse_cnt}, 0);
    exp_cnt = 0;
    i_reset = 1'b1;
    tick();
    e0 = cyc;
    check("t6_busy_restart", {31'd0, o_busy}, 1);
    expect_strobe(e0 + 4);
    drain(8);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
